// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: RV32I access-size codes
// and the arbitration state encoding.
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for the largest legal starvation limit (15).
    localparam int CNT_W = 4;

    typedef enum logic {
        CORE_PRI  = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/dmem_align_check.sv
// Combinational alignment check for an RV32I load/store: flags accesses whose
// address is not a multiple of the access size, and any unsupported funct3.
module dmem_align_check
    import dmem_arbiter_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] addr_lo,
    output logic       misaligned
);

    always_comb begin
        misaligned = 1'b0;
        unique case (funct3)
            F3_B, F3_BU: misaligned = 1'b0;
            F3_H, F3_HU: misaligned = addr_lo[0];
            F3_W:        misaligned = (addr_lo != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: the core has fixed
// priority, the debug port is forced through after STARVE_LIMIT denials.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     core_req,
    input  logic                     core_we,
    input  logic [2:0]               core_funct3,
    input  logic [ADDRESS_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0]    core_wdata,
    output logic                     core_gnt,
    output logic                     core_stall,
    output logic                     core_rvalid,
    output logic [DATA_WIDTH-1:0]    core_rdata,
    output logic                     core_err,

    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [ADDRESS_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]    dbg_wdata,
    output logic                     dbg_gnt,
    output logic                     dbg_rvalid,
    output logic [DATA_WIDTH-1:0]    dbg_rdata,

    output logic                     mem_write_e,
    output logic [2:0]               mem_funct3,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,

    output arb_state_t               arb_state,
    output logic [CNT_W-1:0]         arb_starve_cnt
);

    localparam logic [CNT_W-1:0]         LIMIT    = CNT_W'(STARVE_LIMIT);
    localparam logic [ADDRESS_WIDTH-1:0] WORD_MSK = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt, next_cnt;
    logic             core_misaligned;

    dmem_align_check u_align (
        .funct3     (core_funct3),
        .addr_lo    (core_addr[1:0]),
        .misaligned (core_misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CORE_PRI;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = starve_cnt;
        unique case (state)
            CORE_PRI: begin
                if (dbg_gnt) begin
                    next_cnt = '0;
                end else if (dbg_req && core_gnt) begin
                    next_cnt = starve_cnt + 1'b1;
                    if (next_cnt == LIMIT) next_state = DBG_FORCE;
                end
            end
            DBG_FORCE: begin
                next_state = CORE_PRI;
                next_cnt   = '0;
            end
            default: begin
                next_state = CORE_PRI;
                next_cnt   = '0;
            end
        endcase
    end

    // Grants and the memory-side mux; idle cycles drive all mem_* to zero.
    always_comb begin
        core_gnt    = 1'b0;
        dbg_gnt     = 1'b0;
        mem_write_e = 1'b0;
        mem_funct3  = 3'b000;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (state == DBG_FORCE) begin
            dbg_gnt = dbg_req;
        end else begin
            core_gnt = core_req;
            dbg_gnt  = dbg_req && !core_req;
        end
        if (core_gnt) begin
            mem_write_e = core_we && !core_misaligned;
            mem_funct3  = core_funct3;
            mem_addr    = core_addr;
            mem_wdata   = core_wdata;
        end else if (dbg_gnt) begin
            mem_write_e = dbg_we;
            mem_funct3  = F3_W;
            mem_addr    = dbg_addr & WORD_MSK;
            mem_wdata   = dbg_wdata;
        end
    end

    assign core_stall     = core_req && !core_gnt;
    assign arb_state      = state;
    assign arb_starve_cnt = starve_cnt;

    // A misaligned access returns an error response and clears the data,
    // whether it was a load or a store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rvalid <= 1'b0;
            core_err    <= 1'b0;
            core_rdata  <= '0;
        end else begin
            core_rvalid <= core_gnt && (!core_we || core_misaligned);
            core_err    <= core_gnt && core_misaligned;
            if (core_gnt && core_misaligned) begin
                core_rdata <= '0;
            end else if (core_gnt && !core_we) begin
                core_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_gnt && !dbg_we;
            if (dbg_gnt && !dbg_we) begin
                dbg_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-port accesses, contention and
// starvation, misalignment errors, reset mid-access and debug withdrawal.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        core_req, core_we;
    logic [2:0]  core_funct3;
    logic [31:0] core_addr, core_wdata;
    logic        core_gnt, core_stall, core_rvalid, core_err;
    logic [31:0] core_rdata;
    logic        dbg_req, dbg_we;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_write_e;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    arb_state_t  arb_state;
    logic [3:0]  arb_starve_cnt;

    int n_checks;
    int n_errors;

    dmem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core_req       (core_req),
        .core_we        (core_we),
        .core_funct3    (core_funct3),
        .core_addr      (core_addr),
        .core_wdata     (core_wdata),
        .core_gnt       (core_gnt),
        .core_stall     (core_stall),
        .core_rvalid    (core_rvalid),
        .core_rdata     (core_rdata),
        .core_err       (core_err),
        .dbg_req        (dbg_req),
        .dbg_we         (dbg_we),
        .dbg_addr       (dbg_addr),
        .dbg_wdata      (dbg_wdata),
        .dbg_gnt        (dbg_gnt),
        .dbg_rvalid     (dbg_rvalid),
        .dbg_rdata      (dbg_rdata),
        .mem_write_e    (mem_write_e),
        .mem_funct3     (mem_funct3),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .arb_state      (arb_state),
        .arb_starve_cnt (arb_starve_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // driver tasks: inputs change 1 ns after the rising edge
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        core_req = 1'b0; core_we = 1'b0; core_funct3 = 3'b000;
        core_addr = '0; core_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        mem_rdata = '0;
    endtask

    task automatic drive_core(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
        core_req = 1'b1; core_we = we; core_funct3 = f3; core_addr = addr; core_wdata = wdata;
    endtask

    task automatic drive_dbg(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    endtask

    // Issue one core access alone, then check the response one cycle later.
    task automatic core_access(input string tag, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] rd,
                               input logic exp_we, input logic exp_rvalid,
                               input logic exp_err, input logic [31:0] exp_rdata);
        drive_core(we, f3, addr, 32'h0BAD_F00D);
        mem_rdata = rd;
        @(negedge clk);
        check_eq({tag, "_gnt"}, 32'(core_gnt), 32'd1);
        check_eq({tag, "_stall"}, 32'(core_stall), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_write_e), 32'(exp_we));
        next_cycle();
        idle();
        @(negedge clk);
        check_eq({tag, "_rvalid"}, 32'(core_rvalid), 32'(exp_rvalid));
        check_eq({tag, "_err"}, 32'(core_err), 32'(exp_err));
        check_eq({tag, "_rdata"}, core_rdata, exp_rdata);
        next_cycle();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst_n = 1'b0;
        #2;
        check_eq("rst_core_rvalid", 32'(core_rvalid), 32'd0);
        check_eq("rst_core_err", 32'(core_err), 32'd0);
        check_eq("rst_dbg_rvalid", 32'(dbg_rvalid), 32'd0);
        check_eq("rst_core_rdata", core_rdata, 32'd0);
        check_eq("rst_dbg_rdata", dbg_rdata, 32'd0);
        check_eq("rst_state", 32'(arb_state), 32'(CORE_PRI));
        check_eq("rst_cnt", 32'(arb_starve_cnt), 32'd0);
        check_eq("rst_mem", {mem_addr[29:0], mem_write_e, |mem_funct3} | mem_wdata, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // core lw
        drive_core(1'b0, F3_W, 32'h10, 32'h0);
        mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check_eq("lw_gnt", 32'(core_gnt), 32'd1);
        check_eq("lw_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check_eq("lw_mem_addr", mem_addr, 32'h10);
        check_eq("lw_mem_f3", 32'(mem_funct3), 32'd2);
        check_eq("lw_mem_we", 32'(mem_write_e), 32'd0);
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("lw_rvalid", 32'(core_rvalid), 32'd1);
        check_eq("lw_rdata", core_rdata, 32'hDEAD_BEEF);
        check_eq("lw_err", 32'(core_err), 32'd0);
        next_cycle();
        @(negedge clk);
        check_eq("lw_rvalid_pulse", 32'(core_rvalid), 32'd0);
        check_eq("lw_rdata_hold", core_rdata, 32'hDEAD_BEEF);
        next_cycle();

        // dbg sw with unaligned address bits ignored
        drive_dbg(1'b1, 32'h23, 32'h1234_5678);
        @(negedge clk);
        check_eq("dsw_gnt", 32'(dbg_gnt), 32'd1);
        check_eq("dsw_mem_addr", mem_addr, 32'h20);
        check_eq("dsw_mem_f3", 32'(mem_funct3), 32'd2);
        check_eq("dsw_mem_we", 32'(mem_write_e), 32'd1);
        check_eq("dsw_mem_wdata", mem_wdata, 32'h1234_5678);
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("dsw_no_rvalid", 32'(dbg_rvalid), 32'd0);
        next_cycle();

        // dbg lw
        drive_dbg(1'b0, 32'h40, 32'h0);
        mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check_eq("dlw_gnt", 32'(dbg_gnt), 32'd1);
        next_cycle();
        idle();
        @(negedge clk);
        check_eq("dlw_rvalid", 32'(dbg_rvalid), 32'd1);
        check_eq("dlw_rdata", dbg_rdata, 32'hCAFE_F00D);
        check_eq("dlw_core_quiet", 32'(core_rvalid), 32'd0);
        next_cycle();

        // contention: period 5, dbg forced every fifth cycle
        drive_core(1'b0, F3_W, 32'h8, 32'h0);
        drive_dbg(1'b0, 32'h80, 32'h0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq($sformatf("cont%0d_core_gnt", i), 32'(core_gnt), 32'((i % 5) != 4));
            check_eq($sformatf("cont%0d_dbg_gnt", i), 32'(dbg_gnt), 32'((i % 5) == 4));
            check_eq($sformatf("cont%0d_stall", i), 32'(core_stall), 32'((i % 5) == 4));
            next_cycle();
        end
        idle();
        @(negedge clk);
        check_eq("cont_end_state", 32'(arb_state), 32'(CORE_PRI));
        check_eq("cont_end_cnt", 32'(arb_starve_cnt), 32'd0);
        next_cycle();

        // misalignment and unsupported sizes
        core_access("sh_mis", 1'b1, F3_H, 32'h05, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, 32'h0);
        core_access("lh_ok", 1'b0, F3_H, 32'h06, 32'h0000_BEEF, 1'b0, 1'b1, 1'b0, 32'h0000_BEEF);
        core_access("lw_mis", 1'b0, F3_W, 32'h02, 32'h1111_1111, 1'b0, 1'b1, 1'b1, 32'h0);
        core_access("sb_ok", 1'b1, F3_B, 32'h03, 32'h2222_2222, 1'b1, 1'b0, 1'b0, 32'h0);
        core_access("f3_011", 1'b0, 3'b011, 32'h00, 32'h3333_3333, 1'b0, 1'b1, 1'b1, 32'h0);
        core_access("lhu_mis", 1'b0, F3_HU, 32'h0B, 32'h4444_4444, 1'b0, 1'b1, 1'b1, 32'h0);

        // reset while a core load is in flight, with starvation partly counted
        drive_core(1'b0, F3_W, 32'h30, 32'h0);
        drive_dbg(1'b0, 32'h90, 32'h0);
        mem_rdata = 32'h7777_7777;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rmid_cnt_before", 32'(arb_starve_cnt), 32'd2);
        check_eq("rmid_gnt", 32'(core_gnt), 32'd1);
        #1;
        rst_n = 1'b0;
        next_cycle();
        check_eq("rmid_rvalid", 32'(core_rvalid), 32'd0);
        check_eq("rmid_state", 32'(arb_state), 32'(CORE_PRI));
        check_eq("rmid_cnt", 32'(arb_starve_cnt), 32'd0);
        idle();
        rst_n = 1'b1;
        next_cycle();

        // dbg withdraws in its forced cycle
        drive_core(1'b0, F3_W, 32'h14, 32'h0);
        drive_dbg(1'b0, 32'hA0, 32'h0);
        for (int i = 0; i < 4; i++) next_cycle();
        check_eq("wd_state_forced", 32'(arb_state), 32'(DBG_FORCE));
        dbg_req = 1'b0;
        @(negedge clk);
        check_eq("wd_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check_eq("wd_core_gnt", 32'(core_gnt), 32'd0);
        check_eq("wd_stall", 32'(core_stall), 32'd1);
        next_cycle();
        @(negedge clk);
        check_eq("wd_core_gnt_next", 32'(core_gnt), 32'd1);
        check_eq("wd_state_next", 32'(arb_state), 32'(CORE_PRI));
        check_eq("wd_cnt_next", 32'(arb_starve_cnt), 32'd0);
        next_cycle();
        idle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline memory stage (core port) and a debug/loader port (dbg port).
- Fixed priority goes to the core. A starvation counter forces a debug grant after STARVE_LIMIT consecutive denials.
- Read responses are registered, so each port sees rvalid one cycle after its grant.
- Misaligned core accesses are blocked and reported. The block sits between the memory stage and the data memory.

Parameters:
- ADDRESS_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- STARVE_LIMIT, 4, consecutive cycles dbg_req may be denied before dbg is forced; legal range 1..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = store, 0 = load
- core_funct3  in  3  RV32I load/store funct3
- core_addr  in  ADDRESS_WIDTH  byte address
- core_wdata  in  DATA_WIDTH  store data
- core_gnt  out  1  request accepted this cycle (combinational)
- core_stall  out  1  core_req & ~core_gnt, freezes the pipeline
- core_rvalid  out  1  registered: load data or error valid
- core_rdata  out  DATA_WIDTH  registered load data
- core_err  out  1  registered: misaligned access, valid with core_rvalid
- dbg_req  in  1  debug request, held until granted
- dbg_we  in  1  1 = word store, 0 = word load
- dbg_addr  in  ADDRESS_WIDTH  word-aligned byte address; bits [1:0] ignored, forced to 0
- dbg_wdata  in  DATA_WIDTH  store data
- dbg_gnt  out  1  request accepted this cycle
- dbg_rvalid  out  1  registered: load data valid
- dbg_rdata  out  DATA_WIDTH  registered load data
- mem_write_e  out  1  write enable to data memory
- mem_funct3  out  3  access size to data memory
- mem_addr  out  ADDRESS_WIDTH  address to data memory
- mem_wdata  out  DATA_WIDTH  write data to data memory
- mem_rdata  in  DATA_WIDTH  asynchronous read data from data memory

Behaviour:
- Reset (rst_n low, async):
  - State CORE_PRI, starve_cnt = 0.
  - core_rvalid, core_err, dbg_rvalid = 0; core_rdata, dbg_rdata = 0.
  - Combinational outputs follow from the reset state. With no requests, all mem_* outputs are 0.
- State CORE_PRI:
  - core_req granted if present. Otherwise dbg_req granted if present.
  - Each cycle with dbg_req & core_gnt: starve_cnt++.
  - When starve_cnt reaches STARVE_LIMIT, go to DBG_FORCE on that edge.
  - Any dbg grant clears starve_cnt.
- State DBG_FORCE:
  - dbg granted unconditionally; core_gnt = 0, so core_stall = core_req.
  - Next state CORE_PRI, starve_cnt = 0.
  - If dbg_req drops while in DBG_FORCE: no grant, return to CORE_PRI.
- Exactly one of core_gnt / dbg_gnt is high per cycle, or neither.
- Mux: the mem_* outputs carry the granted port's fields. A dbg grant drives mem_funct3 = 3'b010.
  - A store commits at the edge ending the grant cycle.
  - A load samples mem_rdata at that edge into the port's rdata register. rvalid pulses for exactly one cycle after the grant (latency 1).
  - Stores produce no rvalid.
- Misalign check (core only):
  - funct3[1:0] = 01 with addr[0] = 1 is misaligned.
  - funct3 = 010 with addr[1:0] ≠ 00 is misaligned.
  - A misaligned access is still granted (consumes the slot, no stall). mem_write_e is forced 0.
  - Next cycle core_rvalid = 1, core_err = 1, core_rdata = 0. Applies to loads and stores.
- Unsupported funct3 (011, 110, 111): treated as misaligned (error).
- Back-to-back grants are allowed every cycle. rdata registers hold their value until the next load on the same port.
- A reset mid-access drops any pending rvalid. A store already committed at an earlier edge is not undone.

Decomposition:
- Shared package: funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU; state encoding CORE_PRI / DBG_FORCE.
- One sub-module: dmem_align_check (combinational funct3/addr → misaligned), reusable by the LSU.

Test Plan:
- Core only: lw addr 0x10 with mem_rdata 0xDEADBEEF → core_gnt same cycle; next cycle core_rvalid = 1, core_rdata = 0xDEADBEEF, core_err = 0.
- Dbg only: sw addr 0x23, wdata 0x12345678 → dbg_gnt; mem_addr = 0x20, mem_funct3 = 010, mem_write_e = 1; no dbg_rvalid.
- Contention: core_req and dbg_req held high continuously, STARVE_LIMIT = 4:
  - Core granted for 4 cycles, then dbg for 1 cycle with core_stall = 1, then core again.
  - The pattern repeats with period 5.
- Misaligned: core sh at addr 0x05 → core_gnt = 1, mem_write_e = 0; next cycle core_rvalid = 1, core_err = 1, core_rdata = 0.
- Reset mid-operation: core lw granted, rst_n pulled low before the next edge → core_rvalid stays 0, state CORE_PRI, starve_cnt = 0.
- Dbg withdraws in DBG_FORCE: drop dbg_req in the forced cycle → no grant that cycle, core granted the following cycle.
